conv_encoder: RTL

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder.sv | 117 +++++++++++
 1 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2, K=7 feedforward convolutional encoder (G0=171, G1=133 octal).
// Frames of FRAME_LEN information bits, optionally flushed with 6 zero tail bits.
module conv_encoder #(
  parameter int unsigned FRAME_LEN = 32,
  parameter int unsigned TAIL_EN   = 1
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       d_in_valid,
  input  logic       d_in,
  output logic       d_in_ready,
  output logic       d_out_valid,
  output logic [1:0] d_out,
  output logic       d_out_last,
  output logic       busy
);

  localparam int unsigned CNT_W    = $clog2(FRAME_LEN + 1);
  localparam int unsigned TCNT_W   = 3;
  localparam int unsigned TAIL_LEN = 6;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t              state_q, state_d;
  logic [5:0]          sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                xfer_c;
  logic                enc_en_c;
  logic                u_c;
  logic                last_c;
  logic                g0_c, g1_c;

  assign xfer_c = d_in_valid && d_in_ready;

  // Generator taps on the current bit u and the history s[5:0]
  assign g0_c = u_c ^ sr_q[0] ^ sr_q[1] ^ sr_q[2] ^ sr_q[5];
  assign g1_c = u_c ^ sr_q[1] ^ sr_q[2] ^ sr_q[4] ^ sr_q[5];

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      d_out       <= 2'b00;
      d_out_valid <= 1'b0;
      d_out_last  <= 1'b0;
      d_in_ready  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      d_out       <= enc_en_c ? {g0_c, g1_c} : 2'b00;
      d_out_valid <= enc_en_c;
      d_out_last  <= last_c;
      d_in_ready  <= (state_d != TAIL);
      busy        <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    enc_en_c  = 1'b0;
    u_c       = 1'b0;
    last_c    = 1'b0;
    cnt_inc_c = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE, DATA: begin
        if (xfer_c) begin
          enc_en_c = 1'b1;
          u_c      = d_in;
          sr_d     = {sr_q[4:0], d_in};
          if (cnt_inc_c == CNT_W'(FRAME_LEN)) begin
            cnt_d = '0;
            if (TAIL_EN != 0) begin
              state_d = TAIL;
              tcnt_d  = '0;
            end else begin
              // Without a tail the history must be dropped explicitly
              state_d = IDLE;
              last_c  = 1'b1;
              sr_d    = '0;
            end
          end else begin
            state_d = DATA;
            cnt_d   = cnt_inc_c;
          end
        end
      end
      TAIL: begin
        enc_en_c = 1'b1;
        sr_d     = {sr_q[4:0], 1'b0};
        tcnt_d   = tcnt_q + TCNT_W'(1);
        if (tcnt_q == TCNT_W'(TAIL_LEN - 1)) begin
          state_d = IDLE;
          last_c  = 1'b1;
          tcnt_d  = '0;
          sr_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
        tcnt_d  = '0;
      end
    endcase
  end

endmodule
